// File: rtl/data_memory_pkg.sv
// Shared MIPS memory-access definitions.
// Holds the MemMode access-size encodings used by both the controller and the
// data memory, plus a helper that pulls a zero-extended load value out of a word.
package data_memory_pkg;

  // Access size carried on MemMode.
  typedef enum logic [1:0] {
    MODE_WORD = 2'b00,
    MODE_HALF = 2'b01,
    MODE_BYTE = 2'b10,
    MODE_RSVD = 2'b11
  } mem_mode_e;

  localparam int unsigned WordBytes = 4;

  // Shift the selected lane down to bit 0 and zero-extend to the access size.
  function automatic logic [31:0] lane_extract(logic [31:0] word, logic [1:0] lane,
                                               logic [1:0] mode);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> {lane, 3'b000};
    unique case (mem_mode_e'(mode))
      MODE_WORD: result = word;
      MODE_HALF: result = {16'h0000, shifted[15:0]};
      MODE_BYTE: result = {24'h000000, shifted[7:0]};
      default:   result = 32'h0000_0000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// CPU <-> data memory bus.
//   MemWrite      write strobe, 1 = store this cycle
//   MemMode       access size (see mem_mode_e)
//   memAddr       16-bit byte address
//   writeMemData  store data, right-justified for sub-word stores
//   memData       registered load data (1-cycle latency)
//   misalign      sticky access-error flag
interface data_memory_if;
  logic        MemWrite;
  logic [1:0]  MemMode;
  logic [15:0] memAddr;
  logic [31:0] writeMemData;
  logic [31:0] memData;
  logic        misalign;

  modport master (
    output MemWrite,
    output MemMode,
    output memAddr,
    output writeMemData,
    input  memData,
    input  misalign
  );

  modport slave (
    input  MemWrite,
    input  MemMode,
    input  memAddr,
    input  writeMemData,
    output memData,
    output misalign
  );
endinterface

// File: rtl/mem_lane_decode.sv
// Combinational lane decoder for the data memory.
//   mode_i      MemMode access size
//   addr_lo_i   memAddr[1:0]
//   write_i     MemWrite
//   byte_we_o   per-byte write enable (little-endian lanes), zero on illegal access
//   legal_o     access is aligned and uses a defined size
//   rd_lane_o   lowest byte lane of the addressed item, used to align load data
module mem_lane_decode
  import data_memory_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic [1:0] addr_lo_i,
  input  logic       write_i,
  output logic [3:0] byte_we_o,
  output logic       legal_o,
  output logic [1:0] rd_lane_o
);

  logic [3:0] lane_mask;

  always_comb begin
    lane_mask = 4'b0000;
    legal_o   = 1'b0;
    rd_lane_o = 2'b00;
    unique case (mem_mode_e'(mode_i))
      MODE_WORD: begin
        legal_o   = (addr_lo_i == 2'b00);
        lane_mask = 4'b1111;
      end
      MODE_HALF: begin
        legal_o   = ~addr_lo_i[0];
        rd_lane_o = {addr_lo_i[1], 1'b0};
        lane_mask = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      MODE_BYTE: begin
        legal_o   = 1'b1;
        rd_lane_o = addr_lo_i;
        lane_mask = 4'b0001 << addr_lo_i;
      end
      default: begin
        legal_o = 1'b0;
      end
    endcase
    byte_we_o = (write_i && legal_o) ? lane_mask : 4'b0000;
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable 32-bit data memory for the MIPS core.
//   clk    sole clock, rising edge
//   reset  asynchronous active-low; clears memData/misalign, never the array
//   bus    data_memory_if slave: MemWrite, MemMode, memAddr, writeMemData in;
//          memData (registered, read-first) and sticky misalign out
// Word index is memAddr[INDEX_W+1:2]; upper address bits alias.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned INDEX_W     = 12
) (
  input logic          clk,
  input logic          reset,
  data_memory_if.slave bus
);

  logic [INDEX_W-1:0] word_idx;
  logic [3:0]         byte_we;
  logic               legal;
  logic [1:0]         rd_lane;
  logic [31:0]        wr_word;
  logic [31:0]        rd_word;
  logic [31:0]        mem_data_d, mem_data_q;
  logic               misalign_d, misalign_q;
  logic [31:0]        mem_q [DEPTH_WORDS];
  logic               unused_addr_hi;

  assign word_idx       = bus.memAddr[INDEX_W+1:2];
  assign unused_addr_hi = ^bus.memAddr[15:INDEX_W+2];

  mem_lane_decode u_lane_decode (
    .mode_i    (bus.MemMode),
    .addr_lo_i (bus.memAddr[1:0]),
    .write_i   (bus.MemWrite),
    .byte_we_o (byte_we),
    .legal_o   (legal),
    .rd_lane_o (rd_lane)
  );

  // Replicate right-justified store data across lanes; byte_we picks the lanes.
  always_comb begin
    wr_word = bus.writeMemData;
    unique case (mem_mode_e'(bus.MemMode))
      MODE_HALF: wr_word = {2{bus.writeMemData[15:0]}};
      MODE_BYTE: wr_word = {4{bus.writeMemData[7:0]}};
      default:   wr_word = bus.writeMemData;
    endcase
  end

  assign rd_word = mem_q[word_idx];

  always_comb begin
    mem_data_d = legal ? lane_extract(rd_word, rd_lane, bus.MemMode) : 32'h0000_0000;
    misalign_d = misalign_q | ~legal;
  end

  // Array has no reset; writes are suppressed while reset is held low so a
  // store coinciding with reset assertion is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < WordBytes; b++) begin
        if (byte_we[b]) begin
          mem_q[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
      end
    end
  end

  // Non-blocking read of mem_q gives read-first behaviour on same-word writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_data_q <= 32'h0000_0000;
      misalign_q <= 1'b0;
    end else begin
      mem_data_q <= mem_data_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.memData  = mem_data_q;
  assign bus.misalign = misalign_q;

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096; number of 32-bit words in the array (16 KiB).
REQ-002 Parameter INDEX_W, default 12; word-index width, equal to log2(DEPTH_WORDS).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 MemWrite  input  1  write strobe from CPU; 1 = write this cycle.
REQ-006 MemMode  input  2  access size: 2'b00 word, 2'b01 halfword, 2'b10 byte, 2'b11 reserved.
REQ-007 memAddr  input  16  byte address from CPU.
REQ-008 writeMemData  input  32  store data from CPU, right-justified for sub-word stores.
REQ-009 memData  output  32  registered load data to CPU.
REQ-010 misalign  output  1  sticky access-error flag.

Function
REQ-011 Byte order SHALL be little-endian: byte lane = memAddr[1:0]; halfword lane = memAddr[1].
REQ-012 Word index SHALL be memAddr[INDEX_W+1:2]; higher address bits SHALL be ignored (aliasing wrap-around).
REQ-013 An access SHALL be legal when: word with memAddr[1:0]==0; half with memAddr[0]==0; byte at any address.
REQ-014 On a rising edge with MemWrite=1 and a legal access, only the addressed lanes SHALL be written: word all 4 bytes from writeMemData[31:0]; half 2 bytes from writeMemData[15:0]; byte 1 byte from writeMemData[7:0].
REQ-015 Unaddressed bytes of the target word SHALL keep their previous value.
REQ-016 On every rising edge, memData SHALL load the addressed data, regardless of MemWrite; read latency exactly 1 cycle.
REQ-017 Load data: word = full word; half = selected halfword zero-extended; byte = selected byte zero-extended (CPU performs sign extension).
REQ-018 Simultaneous read and write of the same word SHALL be read-first: memData receives the pre-write contents; the new value is visible one cycle later.
REQ-019 An illegal access (misaligned, or MemMode=2'b11) SHALL suppress the write, load memData with 32'h0, and set misalign to 1 on that edge.
REQ-020 misalign SHALL stay 1 until reset; no other event clears it.
REQ-021 With inputs held constant, memData SHALL stay stable over consecutive cycles when MemWrite=0.

Reset
REQ-022 While reset=0, memData SHALL be 32'h0 and misalign SHALL be 0, immediately, without waiting for a clock edge.
REQ-023 Reset SHALL NOT clear array contents; a write on the edge coinciding with reset assertion SHALL be dropped.
REQ-024 On the first rising edge after reset deasserts, normal operation per REQ-014..REQ-020 SHALL resume.

Structure
REQ-025 MemMode encodings (MODE_WORD, MODE_HALF, MODE_BYTE, MODE_RSVD) SHALL live in the shared mips definitions package/header and be used by both controller and data_memory.
REQ-026 One sub-module, mem_lane_decode, SHALL be combinational: (MemMode, memAddr[1:0], MemWrite) -> 4-bit byte-write enable, legal flag, and a read-lane select.
REQ-027 Array SHALL be a DEPTH_WORDS x 32 register array written per byte lane, inferable as byte-enable RAM.

Verification
REQ-028 Word write 32'hDEADBEEF @16'h0010, then read word @16'h0010 -> memData=32'hDEADBEEF one cycle after the read address is presented.
REQ-029 Byte write 8'hAA @16'h0013 over 32'h11223344 @16'h0010, then word read -> 32'hAA223344; byte read @16'h0013 -> 32'h000000AA.
REQ-030 Half write 16'h5566 @16'h0022, then half read @16'h0022 -> 32'h00005566; word read @16'h0020 -> upper half 16'h5566, lower half unchanged.
REQ-031 Word write @16'h0031 -> array unchanged, memData=0, misalign=1; misalign stays 1 through 10 further legal accesses; reset=0 -> misalign=0 and memData=0 asynchronously.
REQ-032 Write 32'h0 over 32'hCAFEF00D @16'h0040 with a same-cycle read -> memData=32'hCAFEF00D that cycle, 32'h0 the next cycle.
REQ-033 Word write 32'h12345678 @16'h4004 with default depth -> word read @16'h0004 returns 32'h12345678 (alias wrap).
